// File: rtl/tape_pkg.sv
// Shared types and constants for the Specialist cassette-save decoder.
// The optional inverted-polarity sync detection is controlled by TAPE_DECODER_INVERT_DETECT_EN.
package tape_pkg;

    localparam int CNT_W = 12;
    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hE6;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LEADER = 2'd1,
        ST_SYNC   = 2'd2,
        ST_DATA   = 2'd3
    } tape_state_t;

    typedef enum logic [1:0] {
        CLS_G = 2'd0,
        CLS_S = 2'd1,
        CLS_L = 2'd2
    } iv_class_t;

    // Glitch below the first threshold, half-bit below the split, full bit otherwise.
    function automatic iv_class_t classify_interval(input logic [CNT_W-1:0] value,
                                                    input logic [CNT_W-1:0] glitch_th,
                                                    input logic [CNT_W-1:0] split_th);
        if (value < glitch_th) begin
            return CLS_G;
        end
        if (value < split_th) begin
            return CLS_S;
        end
        return CLS_L;
    endfunction

endpackage

// File: rtl/tape_fifo.sv
// Small synchronous byte FIFO with a registered head, used to buffer decoded tape bytes.
// A push and a pop in the same cycle are both honoured, even when the FIFO is full.
module tape_fifo
    import tape_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       push,
    input  logic [7:0] wr_data,
    input  logic       pop_req,
    output logic [7:0] head,
    output logic       empty,
    output logic       full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] rd_ptr_next;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    logic [CW-1:0] remain;
    logic          pop;
    logic          wr;
    logic [7:0]    head_next;

    assign full = (count == CW'(DEPTH));

    // When the FIFO drains to nothing in this cycle, the incoming byte becomes the head directly.
    always_comb begin
        pop         = pop_req && !empty;
        wr          = push && (!full || pop);
        rd_ptr_next = rd_ptr + AW'(pop);
        remain      = count - CW'(pop);
        count_next  = remain + CW'(wr);
        if (remain == '0) begin
            head_next = wr_data;
        end else begin
            head_next = mem[rd_ptr_next];
        end
    end

    always_ff @(posedge clk_sys) begin
        if (wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            head   <= 8'h00;
            empty  <= 1'b1;
        end else begin
            wr_ptr <= wr_ptr + AW'(wr);
            rd_ptr <= rd_ptr_next;
            count  <= count_next;
            empty  <= (count_next == '0);
            if (count_next != '0) begin
                head <= head_next;
            end
        end
    end

endmodule

// File: rtl/tape_decoder.sv
// Recovers the Manchester bit stream from the CPU tape-out bit: leader, phase lock, sync, data bytes.
// Define TAPE_DECODER_INVERT_DETECT_EN to also lock on an inverted-polarity recording.
module tape_decoder
    import tape_pkg::*;
#(
    parameter int         T_GLITCH   = 32,
    parameter int         T_SPLIT    = 600,
    parameter int         T_TIMEOUT  = 4095,
    parameter int         LEADER_MIN = 32,
    parameter logic [7:0] SYNC_BYTE  = DEFAULT_SYNC_BYTE,
    parameter int         FIFO_DEPTH = 16
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ce,
    input  logic        tape_bit,
    output logic [7:0]  rd_data,
    output logic        rd_valid,
    input  logic        rd_ack,
    output logic        active,
    output logic        done,
    output logic        err,
    output logic        ovf,
    output logic [15:0] byte_cnt
);

    localparam logic [CNT_W-1:0] GLITCH_TH  = CNT_W'(T_GLITCH);
    localparam logic [CNT_W-1:0] SPLIT_TH   = CNT_W'(T_SPLIT);
    localparam logic [CNT_W-1:0] TIMEOUT_TH = CNT_W'(T_TIMEOUT);
    localparam logic [7:0]       LEADER_TH  = 8'(LEADER_MIN);

    tape_state_t      state;
    logic             prev;
    logic             edge_det;
    logic [CNT_W-1:0] cnt;
    logic             ev_valid;
    iv_class_t        ev_cls;
    logic             ev_level;
    logic [7:0]       lead;
    logic             phase_mid;
    logic [6:0]       shreg;
    logic [2:0]       bit_cnt;
    logic             emit;
    logic             data_bit;
    logic [7:0]       shift_next;
    logic             byte_push;
    logic             fifo_empty;
    logic             fifo_full;
    logic             fifo_ready;
`ifdef TAPE_DECODER_INVERT_DETECT_EN
    logic             invert;
`endif

    assign edge_det   = tape_bit ^ prev;
    assign active     = (state == ST_SYNC) || (state == ST_DATA);
    assign rd_valid   = !fifo_empty;
    assign fifo_ready = !fifo_full || (rd_ack && rd_valid);

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (edge_det) begin
            cnt <= '0;
        end else if (ce && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

    // A short edge flips phase and yields a bit when it lands mid-bit; a long edge is always mid-bit.
    always_comb begin
        emit = 1'b0;
        if (ev_valid && active) begin
            case (ev_cls)
                CLS_S:   emit = !phase_mid;
                CLS_L:   emit = phase_mid;
                default: emit = 1'b0;
            endcase
        end
`ifdef TAPE_DECODER_INVERT_DETECT_EN
        data_bit = ev_level ^ invert;
`else
        data_bit = ev_level;
`endif
        shift_next = {shreg, (state == ST_DATA) ? data_bit : ev_level};
        byte_push  = emit && (state == ST_DATA) && (bit_cnt == 3'd7);
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            prev      <= 1'b0;
            ev_valid  <= 1'b0;
            ev_cls    <= CLS_G;
            ev_level  <= 1'b0;
            lead      <= 8'd0;
            phase_mid <= 1'b0;
            shreg     <= 7'd0;
            bit_cnt   <= 3'd0;
            done      <= 1'b0;
            err       <= 1'b0;
            ovf       <= 1'b0;
            byte_cnt  <= 16'd0;
`ifdef TAPE_DECODER_INVERT_DETECT_EN
            invert    <= 1'b0;
`endif
        end else begin
            prev     <= tape_bit;
            ev_valid <= edge_det;
            if (edge_det) begin
                ev_cls   <= classify_interval(cnt, GLITCH_TH, SPLIT_TH);
                ev_level <= tape_bit;
            end
            done <= 1'b0;

            if (byte_push) begin
                if (fifo_ready) begin
                    byte_cnt <= byte_cnt + 16'd1;
                end else begin
                    ovf <= 1'b1;
                end
            end

            if (ev_valid) begin
                case (state)
                    ST_IDLE: begin
                        if (ev_cls == CLS_S) begin
                            lead  <= 8'd1;
                            state <= ST_LEADER;
                        end
                    end
                    ST_LEADER: begin
                        case (ev_cls)
                            CLS_S: begin
                                if (lead != 8'hFF) begin
                                    lead <= lead + 8'd1;
                                end
                            end
                            CLS_G: begin
                                lead  <= 8'd0;
                                state <= ST_IDLE;
                            end
                            default: begin
                                if (lead >= LEADER_TH) begin
                                    state     <= ST_SYNC;
                                    phase_mid <= 1'b1;
                                    shreg     <= {6'd0, ev_level};
                                    err       <= 1'b0;
                                    ovf       <= 1'b0;
                                    byte_cnt  <= 16'd0;
                                end else begin
                                    state <= ST_IDLE;
                                end
                            end
                        endcase
                    end
                    default: begin
                        if ((ev_cls == CLS_G) || ((ev_cls == CLS_L) && !phase_mid)) begin
                            err   <= 1'b1;
                            state <= ST_IDLE;
                        end else begin
                            if (ev_cls == CLS_S) begin
                                phase_mid <= !phase_mid;
                            end
                            if (emit) begin
                                shreg <= shift_next[6:0];
                                if (state == ST_SYNC) begin
                                    if (shift_next == SYNC_BYTE) begin
                                        state   <= ST_DATA;
                                        bit_cnt <= 3'd0;
                                    end
`ifdef TAPE_DECODER_INVERT_DETECT_EN
                                    else if (shift_next == ~SYNC_BYTE) begin
                                        state   <= ST_DATA;
                                        bit_cnt <= 3'd0;
                                        invert  <= 1'b1;
                                    end
`endif
                                end else begin
                                    bit_cnt <= bit_cnt + 3'd1;
                                end
                            end
                        end
                    end
                endcase
            end else if ((state != ST_IDLE) && (cnt >= TIMEOUT_TH)) begin
                state <= ST_IDLE;
                done  <= (state == ST_DATA);
            end

`ifdef TAPE_DECODER_INVERT_DETECT_EN
            if (state == ST_IDLE) begin
                invert <= 1'b0;
            end
`endif
        end
    end

    tape_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk_sys (clk_sys),
        .reset   (reset),
        .push    (byte_push),
        .wr_data (shift_next),
        .pop_req (rd_ack),
        .head    (rd_data),
        .empty   (fifo_empty),
        .full    (fifo_full)
    );

endmodule

// File: tb/tb_tape_decoder.sv
// Directed bench for tape_decoder: synthesises Manchester tape waveforms and checks the decoded FIFO stream.
// Thresholds are scaled down so each recording takes only a few thousand clocks.
module tb_tape_decoder;

    localparam int S_TICKS    = 10;
    localparam int L_TICKS    = 20;
    localparam int IDLE_TICKS = 250;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        ce = 1'b0;
    logic        tape_bit;
    logic [7:0]  rd_data;
    logic        rd_valid;
    logic        rd_ack;
    logic        active;
    logic        done;
    logic        err;
    logic        ovf;
    logic [15:0] byte_cnt;

    int checks = 0;
    int errors = 0;
    int done_pulses = 0;
    int active_cycles = 0;
    int snap;
    logic last_bit;

    tape_decoder #(
        .T_GLITCH   (4),
        .T_SPLIT    (15),
        .T_TIMEOUT  (200),
        .LEADER_MIN (32),
        .SYNC_BYTE  (8'hE6),
        .FIFO_DEPTH (16)
    ) dut (
        .clk_sys  (clk_sys),
        .reset    (reset),
        .ce       (ce),
        .tape_bit (tape_bit),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .rd_ack   (rd_ack),
        .active   (active),
        .done     (done),
        .err      (err),
        .ovf      (ovf),
        .byte_cnt (byte_cnt)
    );

    initial forever #5 clk_sys = ~clk_sys;

    // Tick enable on every other clock so the counter's ce gating matters.
    initial forever begin
        @(negedge clk_sys);
        ce = ~ce;
    end

    always @(posedge clk_sys) begin
        if (done) done_pulses <= done_pulses + 1;
        if (active) active_cycles <= active_cycles + 1;
    end

    initial begin
        #2ms;
        $display("[TB] FAIL watchdog: observed no finish, expected finish within 2ms");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic wait_ticks(input int n);
        repeat (2 * n) @(negedge clk_sys);
    endtask

    task automatic toggle_after(input int n);
        wait_ticks(n);
        tape_bit = ~tape_bit;
    endtask

    // Leader ends on the level opposite to the first bit so that bit arrives as a long interval.
    task automatic send_leader(input int n, input logic first_bit);
        for (int i = 0; i < n; i++) toggle_after(S_TICKS);
        if (tape_bit == first_bit) toggle_after(S_TICKS);
        last_bit = tape_bit;
    endtask

    task automatic send_bit(input logic b);
        if (b == last_bit) begin
            toggle_after(S_TICKS);
            toggle_after(S_TICKS);
        end else begin
            toggle_after(L_TICKS);
        end
        last_bit = b;
    endtask

    task automatic send_byte(input logic [7:0] v, input logic inv);
        for (int i = 7; i >= 0; i--) send_bit(v[i] ^ inv);
    endtask

    task automatic pop_check(input string tag, input logic [7:0] expected);
        check_output({tag, "_valid"}, 32'(rd_valid), 32'd1);
        check_output({tag, "_data"}, 32'(rd_data), 32'(expected));
        rd_ack = 1'b1;
        @(negedge clk_sys);
        rd_ack = 1'b0;
    endtask

    task automatic apply_stimulus_lock(input logic inv);
        send_leader(40, inv ? 1'b0 : 1'b1);
        send_byte(8'hE6, inv);
    endtask

    initial begin
        reset    = 1'b1;
        tape_bit = 1'b0;
        rd_ack   = 1'b0;
        last_bit = 1'b0;
        repeat (3) @(negedge clk_sys);
        check_output("rst_rd_valid", 32'(rd_valid), 32'd0);
        check_output("rst_rd_data", 32'(rd_data), 32'd0);
        check_output("rst_active", 32'(active), 32'd0);
        check_output("rst_done", 32'(done), 32'd0);
        check_output("rst_err", 32'(err), 32'd0);
        check_output("rst_ovf", 32'(ovf), 32'd0);
        check_output("rst_byte_cnt", 32'(byte_cnt), 32'd0);
        reset = 1'b0;
        wait_ticks(5);

        $display("[TB] basic recording");
        apply_stimulus_lock(1'b0);
        send_byte(8'h12, 1'b0);
        send_byte(8'h34, 1'b0);
        send_byte(8'hA5, 1'b0);
        wait_ticks(5);
        check_output("t1_active", 32'(active), 32'd1);
        check_output("t1_byte_cnt", 32'(byte_cnt), 32'd3);
        wait_ticks(IDLE_TICKS);
        check_output("t1_idle", 32'(active), 32'd0);
        pop_check("t1_b0", 8'h12);
        pop_check("t1_b1", 8'h34);
        pop_check("t1_b2", 8'hA5);
        check_output("t1_empty", 32'(rd_valid), 32'd0);

        $display("[TB] short leader");
        snap = active_cycles;
        for (int i = 0; i < 20; i++) toggle_after(S_TICKS);
        toggle_after(L_TICKS);
        wait_ticks(IDLE_TICKS);
        check_output("t2_active_cycles", 32'(active_cycles - snap), 32'd0);
        check_output("t2_empty", 32'(rd_valid), 32'd0);

        $display("[TB] timeout ends recording");
        snap = done_pulses;
        apply_stimulus_lock(1'b0);
        send_byte(8'hC3, 1'b0);
        send_byte(8'h0F, 1'b0);
        wait_ticks(IDLE_TICKS);
        check_output("t3_done_pulses", 32'(done_pulses - snap), 32'd1);
        check_output("t3_idle", 32'(active), 32'd0);
        check_output("t3_byte_cnt", 32'(byte_cnt), 32'd2);
        pop_check("t3_b0", 8'hC3);
        pop_check("t3_b1", 8'h0F);
        check_output("t3_empty", 32'(rd_valid), 32'd0);

        $display("[TB] overflow");
        apply_stimulus_lock(1'b0);
        for (int i = 0; i < 20; i++) send_byte(8'(i * 37 + 5), 1'b0);
        wait_ticks(IDLE_TICKS);
        check_output("t4_ovf", 32'(ovf), 32'd1);
        check_output("t4_byte_cnt", 32'(byte_cnt), 32'd16);
        check_output("t4_err", 32'(err), 32'd0);
        for (int i = 0; i < 16; i++) pop_check($sformatf("t4_b%0d", i), 8'(i * 37 + 5));
        check_output("t4_empty", 32'(rd_valid), 32'd0);

        $display("[TB] glitch in data");
        apply_stimulus_lock(1'b0);
        toggle_after(1);
        wait_ticks(5);
        check_output("t5_err_set", 32'(err), 32'd1);
        check_output("t5_idle", 32'(active), 32'd0);
        wait_ticks(IDLE_TICKS);
        apply_stimulus_lock(1'b0);
        wait_ticks(5);
        check_output("t5_err_clear", 32'(err), 32'd0);
        check_output("t5_ovf_clear", 32'(ovf), 32'd0);
        check_output("t5_active", 32'(active), 32'd1);
        wait_ticks(IDLE_TICKS);

        $display("[TB] inverted recording");
        snap = done_pulses;
        apply_stimulus_lock(1'b1);
        send_byte(8'h5A, 1'b1);
        wait_ticks(IDLE_TICKS);
`ifdef TAPE_DECODER_INVERT_DETECT_EN
        check_output("t6_done_pulses", 32'(done_pulses - snap), 32'd1);
        pop_check("t6_b0", 8'h5A);
        check_output("t6_empty", 32'(rd_valid), 32'd0);
`else
        check_output("t6_done_pulses", 32'(done_pulses - snap), 32'd0);
        check_output("t6_empty", 32'(rd_valid), 32'd0);
`endif

        $display("[TB] asynchronous reset mid-stream");
        apply_stimulus_lock(1'b0);
        send_byte(8'h77, 1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        wait_ticks(2);
        check_output("t7_valid_before", 32'(rd_valid), 32'd1);
        check_output("t7_cnt_before", 32'(byte_cnt), 32'd1);
        #3;
        reset = 1'b1;
        #1;
        check_output("t7_valid_after", 32'(rd_valid), 32'd0);
        check_output("t7_cnt_after", 32'(byte_cnt), 32'd0);
        check_output("t7_active_after", 32'(active), 32'd0);
        @(negedge clk_sys);
        reset = 1'b0;
        @(negedge clk_sys);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tape_decoder.md
# tape_decoder

Cassette-save decoder for the Specialist core: watches the CPU's tape-out bit (system PPI port C, shared with the speaker bit) and recovers the Manchester bit stream the monitor's save routine produces. It detects leader, locks phase, finds the sync byte, then assembles data bytes into a small FIFO. The HPS side drains the FIFO to build an RKS image. Sits beside the PIT/PPI logic in `clk_sys`, timed by the 2 MHz `ce_pit` enable.

## Interface
Parameters:
- `T_GLITCH`, 32: intervals shorter than this many ticks are noise.
- `T_SPLIT`, 600: boundary; intervals below it are short (half-bit), intervals at or above it are long (full bit).
- `T_TIMEOUT`, 4095: idle ticks with no edge that end a recording.
- `LEADER_MIN`, 32: consecutive short intervals required as leader.
- `SYNC_BYTE`, 8'hE6: byte that ends sync search.
- `FIFO_DEPTH`, 16: power of two.

Ports:
- `clk_sys` in 1: system clock, 96 MHz.
- `reset` in 1: asynchronous, active-high.
- `ce` in 1: 2 MHz tick enable (`ce_pit`).
- `tape_bit` in 1: tape-out level, same clock domain.
- `rd_data` out 8: FIFO head byte.
- `rd_valid` out 1: FIFO non-empty.
- `rd_ack` in 1: pop the head byte when `rd_valid` is high.
- `active` out 1: high in SYNC or DATA.
- `done` out 1: one-cycle pulse when a recording ends by timeout.
- `err` out 1: sticky; glitch inside SYNC or DATA.
- `ovf` out 1: sticky; byte dropped because the FIFO was full.
- `byte_cnt` out 16: bytes accepted into the FIFO; wraps.

## Operation
- Edge detector: register `tape_bit` into `prev`; an edge is `tape_bit ^ prev`. No synchronizer.
- Interval counter: 12-bit, increments on `ce`, saturates at 4095. On an edge, the counter value is classified, then the counter clears in the same cycle.
- Classification: G if below `T_GLITCH`; S if below `T_SPLIT`; otherwise L.
- IDLE:
  - An S edge loads the leader count with 1 and moves to LEADER.
  - G and L edges are ignored.
- LEADER:
  - S increments the leader count, saturating at 255.
  - G clears the count and returns to IDLE.
  - L: if the count is at least `LEADER_MIN`, this edge is mid-bit. Emit bit = `tape_bit` after the edge, set phase=mid, and go to SYNC. If the count is short, go to IDLE.
- Bit recovery (SYNC and DATA):
  - L requires phase=mid. It emits a bit and phase stays mid.
  - S toggles phase. When phase becomes mid, emit a bit.
  - Emitted bit = new `tape_bit` level.
  - L arriving with phase=boundary sets `err` and returns to IDLE.
- SYNC: bits shift MSB-first into an 8-bit register. When the register equals `SYNC_BYTE`, clear the bit counter and go to DATA.
- DATA:
  - Bits shift MSB-first; every 8th bit completes a byte.
  - Byte push: if the FIFO is not full, write the byte and increment `byte_cnt`. If full, drop the byte and set `ovf`.
  - Full-and-pop in the same cycle counts as not full: the write is accepted.
- Timeout: in LEADER, SYNC or DATA, the counter reaching `T_TIMEOUT` returns to IDLE. `done` pulses only if leaving DATA. A partial byte is discarded.
- G in SYNC or DATA sets `err` and returns to IDLE.
- `err` and `ovf` clear on entry to SYNC; `byte_cnt` also clears on entry to SYNC. FIFO contents are kept.
- Reset values: state IDLE, counters 0, FIFO empty, `rd_valid`=0, `active`=0, `done`=0, `err`=0, `ovf`=0, `byte_cnt`=0, `rd_data`=0.

## Timing
- A bit is emitted in the cycle after the edge is registered.
- A completed byte is written to the FIFO on that same emission cycle.
- `rd_valid` and `rd_data` are registered and update one cycle after the write.
- `rd_ack` pops on the clock edge where it and `rd_valid` are both high; the next head appears the following cycle.
- `rd_ack` while empty is ignored.
- Asynchronous reset mid-byte or mid-FIFO clears everything immediately.

## Configuration
- `TAPE_DECODER_INVERT_DETECT_EN` defined:
  - SYNC also matches `~SYNC_BYTE`.
  - On an inverted match, an invert flag is set and every subsequent DATA bit is complemented before shifting.
  - The flag clears on IDLE.
- Macro undefined: only `SYNC_BYTE` matches and no invert logic exists.

## Structure
- Package `tape_pkg`:
  - state enum `tape_state_t` (IDLE, LEADER, SYNC, DATA);
  - interval class enum (G, S, L);
  - counter width constant (12);
  - default `SYNC_BYTE`.
- Sub-module `tape_fifo`: synchronous FIFO, depth `FIFO_DEPTH`, registered head, full/empty flags, simultaneous push/pop.

## Test plan
- 40 S intervals of 300 ticks, then 8'hE6, then bytes 8'h12, 8'h34, 8'hA5 -> three FIFO bytes in order; `byte_cnt`=3.
- 20 S intervals, then an L -> returns to IDLE; `active` never asserts.
- Valid lock, 2 data bytes, then 5000 ticks with no edge -> `done` pulses once; state IDLE; FIFO holds 2 bytes.
- 20 bytes streamed with `rd_ack` never asserted -> 16 stored; `ovf`=1; `byte_cnt`=16. Then pop all -> the 16 come out in order.
- In DATA, an interval of 10 ticks -> `err`=1, IDLE. Then a fresh leader and sync -> `err` cleared.
- With the macro defined: inverted waveform of sync 8'hE6 and data 8'h5A -> FIFO gets 8'h5A.
